// File: rtl/opamp_trim_seq.sv
// Power-up and SAR offset-trim sequencer for an array of op-amp channels.
// START -> DONE takes SETTLE_CYCLES + TRIM_BITS*(SETTLE_CYCLES+1) + 1 cycles; START/TRIM_LOAD are dropped while busy.
module opamp_trim_seq #(
  parameter int CHANNELS      = 4,
  parameter int TRIM_BITS     = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [CHANNELS-1:0]           i_ch_en,
  input  logic [CHANNELS-1:0]           i_cmp,
  input  logic                          i_trim_load,
  input  logic [CHANNELS*TRIM_BITS-1:0] i_trim_wdata,
  output logic [CHANNELS*TRIM_BITS-1:0] o_trim,
  output logic [CHANNELS-1:0]           o_bias_en,
  output logic [CHANNELS-1:0]           o_cal_mode,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int IW = (TRIM_BITS > 1) ? $clog2(TRIM_BITS) : 1;
  localparam logic [CW-1:0]        CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]        IDX_TOP  = IW'(TRIM_BITS - 1);
  localparam logic [TRIM_BITS-1:0] MID      = {1'b1, {(TRIM_BITS-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_POWERUP, S_TRIAL, S_WAIT, S_RUN} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CW-1:0]                   r_cnt, w_cnt_nxt;
  logic [IW-1:0]                   r_idx, w_idx_nxt;
  logic [CHANNELS-1:0]             r_mask, w_mask_nxt;
  logic [CHANNELS-1:0]             r_bias, w_bias_nxt;
  logic [CHANNELS-1:0]             r_cal, w_cal_nxt;
  logic [CHANNELS*TRIM_BITS-1:0]   r_trim, w_trim_nxt;
  logic [CHANNELS*TRIM_BITS-1:0]   r_shadow, w_shadow_nxt;
  logic [CHANNELS-1:0]             r_cmp_s1, r_cmp_s2;
  logic [TRIM_BITS-1:0]            w_code;
  logic                            w_busy;
  logic                            w_load_ok;

  assign w_busy = (r_state == S_POWERUP) || (r_state == S_TRIAL) || (r_state == S_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_s1 <= '0;
      r_cmp_s2 <= '0;
    end else begin
      r_cmp_s1 <= i_cmp;
      r_cmp_s2 <= r_cmp_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_mask   <= '0;
      r_bias   <= '0;
      r_cal    <= '0;
      r_trim   <= {CHANNELS{MID}};
      r_shadow <= {CHANNELS{MID}};
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_mask   <= w_mask_nxt;
      r_bias   <= w_bias_nxt;
      r_cal    <= w_cal_nxt;
      r_trim   <= w_trim_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_mask_nxt   = r_mask;
    w_bias_nxt   = r_bias;
    w_cal_nxt    = r_cal;
    w_shadow_nxt = r_shadow;
    w_code       = '0;
    w_load_ok    = i_trim_load && ((r_state == S_IDLE) || (r_state == S_RUN));
    // A load coincident with START is what the shadow must capture.
    w_trim_nxt   = w_load_ok ? i_trim_wdata : r_trim;

    if (w_busy && i_abort) begin
      w_state_nxt = S_IDLE;
      w_bias_nxt  = '0;
      w_cal_nxt   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (r_mask[k]) w_trim_nxt[k*TRIM_BITS +: TRIM_BITS] = r_shadow[k*TRIM_BITS +: TRIM_BITS];
      end
    end else begin
      case (r_state)
        S_IDLE, S_RUN: begin
          if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_bias_nxt  = '0;
          end else if (i_start) begin
            w_state_nxt  = S_POWERUP;
            w_mask_nxt   = i_ch_en;
            w_bias_nxt   = i_ch_en;
            w_shadow_nxt = w_trim_nxt;
            w_cnt_nxt    = CNT_LOAD;
          end
        end
        S_POWERUP: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_TRIAL;
            w_idx_nxt   = IDX_TOP;
            w_cal_nxt   = r_mask;
            for (int k = 0; k < CHANNELS; k++) begin
              if (r_mask[k]) w_trim_nxt[k*TRIM_BITS +: TRIM_BITS] = MID;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_TRIAL: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            // Decide the current bit and stage the next trial in the same edge.
            for (int k = 0; k < CHANNELS; k++) begin
              if (r_mask[k]) begin
                w_code = r_trim[k*TRIM_BITS +: TRIM_BITS];
                if (r_cmp_s2[k]) w_code[r_idx] = 1'b0;
                if (r_idx != '0) w_code[r_idx - 1'b1] = 1'b1;
                w_trim_nxt[k*TRIM_BITS +: TRIM_BITS] = w_code;
              end
            end
            if (r_idx == '0) begin
              w_state_nxt = S_RUN;
              w_cal_nxt   = '0;
            end else begin
              w_state_nxt = S_TRIAL;
              w_idx_nxt   = r_idx - 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_trim     = r_trim;
  assign o_bias_en  = r_bias;
  assign o_cal_mode = r_cal;
  assign o_busy     = w_busy;
  assign o_done     = (r_state == S_RUN);

endmodule

// File: tb/tb_opamp_trim_seq.sv
// Scoreboard bench for opamp_trim_seq: a behavioural SAR model predicts trial and final codes.
module tb_opamp_trim_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] ch_en = 2'b00;
  logic [1:0] cmp;
  logic       trim_load = 1'b0;
  logic [7:0] trim_wdata = 8'h00;
  logic [7:0] trim;
  logic [1:0] bias_en;
  logic [1:0] cal_mode;
  logic       busy;
  logic       done;

  logic [3:0] tgt [2];
  logic [7:0] cur_trim;
  int         n_chk = 0;
  int         n_pass = 0;

  typedef struct {
    logic [7:0] trim;
    logic [1:0] bias;
    logic [1:0] cal;
    logic       busy;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] trial_q[$];

  opamp_trim_seq #(.CHANNELS(2), .TRIM_BITS(4), .SETTLE_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_ch_en(ch_en),
    .i_cmp(cmp), .i_trim_load(trim_load), .i_trim_wdata(trim_wdata),
    .o_trim(trim), .o_bias_en(bias_en), .o_cal_mode(cal_mode), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  assign cmp[0] = (trim[3:0] > tgt[0]);
  assign cmp[1] = (trim[7:4] > tgt[1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic compare_end(input string name, input exp_t e, input int cyc);
    check({name, "_trim"}, 32'(trim), 32'(e.trim));
    check({name, "_bias"}, 32'(bias_en), 32'(e.bias));
    check({name, "_cal"}, 32'(cal_mode), 32'(e.cal));
    check({name, "_busy"}, 32'(busy), 32'(e.busy));
    check({name, "_done"}, 32'(done), 32'(e.done));
    if (e.done) check({name, "_latency"}, 32'(cyc), 32'(e.cyc));
  endtask

  task automatic load_trim(input logic [7:0] v);
    @(posedge clk); #1;
    trim_load = 1'b1;
    trim_wdata = v;
    @(posedge clk); #1;
    trim_load = 1'b0;
    cur_trim = v;
  endtask

  // stop_at: abort_at (abort pulsed that cycle) or rst_at (reset asserted that cycle); 0 runs to DONE.
  task automatic cal_seq(input string name, input logic [1:0] en, input int abort_at,
                         input int rst_at, input bit poke);
    logic [3:0] code [2];
    logic [3:0] t;
    logic [7:0] tv;
    exp_t       e;
    int         stop_at;
    int         n_cal_err;
    int         n_bias_err;
    bit         ended;
    stop_at = (abort_at != 0) ? abort_at : rst_at;
    code[0] = 4'd0;
    code[1] = 4'd0;
    for (int j = 0; j < 4; j++) begin
      tv = cur_trim;
      for (int c = 0; c < 2; c++) begin
        t = code[c] | 4'(1 << (3 - j));
        if (en[c]) tv[c*4 +: 4] = t;
        if (!(t > tgt[c])) code[c] = t;
      end
      if (stop_at == 0 || (5 + 5*j) <= stop_at) trial_q.push_back(tv);
    end
    if (abort_at != 0) begin
      e = '{trim: cur_trim, bias: 2'b00, cal: 2'b00, busy: 1'b0, done: 1'b0, cyc: abort_at + 1};
    end else if (rst_at != 0) begin
      e = '{trim: 8'h88, bias: 2'b00, cal: 2'b00, busy: 1'b0, done: 1'b0, cyc: rst_at};
    end else begin
      e.trim = cur_trim;
      for (int c = 0; c < 2; c++) if (en[c]) e.trim[c*4 +: 4] = code[c];
      e.bias = en; e.cal = 2'b00; e.busy = 1'b0; e.done = 1'b1; e.cyc = 25;
    end
    sb_q.push_back(e);

    n_cal_err = 0;
    n_bias_err = 0;
    ended = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    ch_en = en;
    for (int cyc = 1; cyc <= 60 && !ended; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      trim_load = 1'b0;
      if (cyc % 5 == 0 && cyc <= 20 && trial_q.size() > 0)
        check({name, "_trial"}, 32'(trim), 32'(trial_q.pop_front()));
      if (rst_at != 0 && cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1 compare_end(name, sb_q.pop_front(), cyc);
        ended = 1'b1;
      end else if ((abort_at != 0 && cyc == abort_at + 1) || (stop_at == 0 && done)) begin
        compare_end(name, sb_q.pop_front(), cyc);
        ended = 1'b1;
      end else begin
        if (cal_mode !== ((cyc >= 5) ? en : 2'b00)) n_cal_err++;
        if (bias_en !== en) n_bias_err++;
        if (poke && cyc == 8) begin
          start = 1'b1;
          trim_load = 1'b1;
          trim_wdata = 8'hFF;
        end
        if (abort_at != 0 && cyc == abort_at) abort = 1'b1;
      end
    end
    if (!ended) begin
      check({name, "_timeout"}, 32'(0), 32'(1));
      void'(sb_q.pop_front());
    end
    check({name, "_cal_errs"}, 32'(n_cal_err), 32'(0));
    check({name, "_bias_errs"}, 32'(n_bias_err), 32'(0));
    trial_q.delete();
    cur_trim = e.trim;
  endtask

  initial begin
    tgt[0] = 4'd9;
    tgt[1] = 4'd3;
    cur_trim = 8'h88;
    #12;
    check("rst_trim", 32'(trim), 32'h88);
    check("rst_bias", 32'(bias_en), 32'h0);
    check("rst_cal", 32'(cal_mode), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    cal_seq("cal11", 2'b11, 0, 0, 1'b0);
    cal_seq("poke", 2'b11, 0, 0, 1'b1);

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    ch_en = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("runabort_trim", 32'(trim), 32'h39);
    check("runabort_bias", 32'(bias_en), 32'h0);
    check("runabort_busy", 32'(busy), 32'h0);
    check("runabort_done", 32'(done), 32'h0);

    load_trim(8'h58);
    cal_seq("cal01", 2'b01, 0, 0, 1'b0);

    load_trim(8'h88);
    cal_seq("abort", 2'b11, 12, 0, 1'b0);

    cal_seq("arst", 2'b11, 0, 10, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur_trim = 8'h88;

    cal_seq("cal00", 2'b00, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/opamp_trim_seq.md
Name: opamp_trim_seq

Overview:
- Digital sequencer for an array of CHANNELS folded-cascode op-amps.
- Per channel it controls power-up (bias enable and settle wait) and offset calibration.
- Calibration is a successive-approximation (SAR) search on a TRIM_BITS offset-trim code, driven by each op-amp's digitised output in open-loop calibration mode.
- It sits between the user-project register bank and the analog op-amp macros.

Parameters:
- CHANNELS, 4: number of op-amp channels controlled.
- TRIM_BITS, 5: width of each channel's offset-trim code.
- SETTLE_CYCLES, 16: clock cycles of analog settling per wait phase. Legal range is 2 or more, because it absorbs the CMP synchroniser latency.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle pulse: begin power-up and calibration.
- ABORT  in  1  single-cycle pulse: stop and return to IDLE.
- CH_EN  in  CHANNELS  channel enable mask, sampled on an accepted START.
- CMP  in  CHANNELS  op-amp output digitised. 1 = output high, meaning the trim is too high. Asynchronous to CLK.
- TRIM_LOAD  in  1  manual trim write strobe.
- TRIM_WDATA  in  CHANNELS*TRIM_BITS  manual trim value. Channel k occupies bits [k*TRIM_BITS +: TRIM_BITS].
- TRIM  out  CHANNELS*TRIM_BITS  current trim codes to the op-amps, using the same packing.
- BIAS_EN  out  CHANNELS  bias current enable per channel.
- CAL_MODE  out  CHANNELS  shorts IN_P to IN_M and puts the channel in open-loop calibration.
- BUSY  out  1  high in POWERUP, TRIAL and WAIT.
- DONE  out  1  high in RUN.

Behaviour:
- Reset values: TRIM = mid-scale per channel (1<<(TRIM_BITS-1)), BIAS_EN = 0, CAL_MODE = 0, BUSY = 0, DONE = 0, state = IDLE, enable mask = 0.
- CMP passes through a 2-flop synchroniser per bit. All decisions use the synchronised value.
- FSM states: IDLE, POWERUP, TRIAL, WAIT, RUN.
- IDLE: START with ABORT low captures CH_EN into the mask and the current TRIM into a shadow register, then goes to POWERUP. BIAS_EN becomes the mask on that transition.
- POWERUP: waits SETTLE_CYCLES cycles, then goes to TRIAL with bit index = TRIM_BITS-1.
- TRIAL (1 cycle):
  - For each masked channel, the trim code is set to 0 except bits above the index, which keep their decided values, and bit[index] is set to 1.
  - CAL_MODE equals the mask from this state until the search ends.
  - Next state is WAIT.
- WAIT: lasts SETTLE_CYCLES cycles. In its last cycle, for each masked channel, synchronised CMP = 1 clears bit[index] and CMP = 0 keeps it.
  - If the index is above 0: decrement the index and go to TRIAL.
  - If the index is 0: go to RUN and clear CAL_MODE.
- RUN:
  - BIAS_EN stays equal to the mask, DONE = 1, and TRIM holds the calibrated codes.
  - START re-captures CH_EN and the shadow register, then goes to POWERUP. BIAS_EN is not dropped for channels that remain enabled.
- Latency: an accepted START in cycle 0 gives DONE = 1 at cycle SETTLE_CYCLES + TRIM_BITS*(SETTLE_CYCLES+1) + 1.
- Unmasked channels: TRIM unchanged, BIAS_EN = 0, CAL_MODE = 0, CMP ignored throughout.
- ABORT in POWERUP, TRIAL or WAIT:
  - Next cycle: state = IDLE, BIAS_EN = 0, CAL_MODE = 0.
  - TRIM of masked channels is restored from the shadow register.
- ABORT in RUN: goes to IDLE, clears BIAS_EN and keeps TRIM.
- ABORT has priority over START in the same cycle.
- START while BUSY is ignored.
- TRIM_LOAD:
  - Accepted only in IDLE or RUN; it writes all channels from TRIM_WDATA on the next edge.
  - Ignored while BUSY.
  - If TRIM_LOAD and START arrive together in IDLE or RUN, the load is applied first and the shadow register captures the loaded value.
- CH_EN = 0 at START: the sequence still runs with all outputs idle, and DONE asserts with the normal latency.
- An asynchronous reset mid-sequence forces all reset values immediately.

Test Plan:
- Settings: CHANNELS=2, TRIM_BITS=4, SETTLE_CYCLES=4. Bench models CMP[k] = (TRIM_k > target_k), with targets 9 and 3, CH_EN = 2'b11, START pulse. Expected response:
  - Channel 0 trials 8, 12, 10, 9 and ends at 9.
  - Channel 1 ends at 3.
  - DONE rises exactly 25 cycles after START.
  - CAL_MODE = 11 during the search and 00 in RUN; BIAS_EN = 11.
- CH_EN = 2'b01, channel 1 TRIM preloaded to 5 via TRIM_LOAD -> channel 1 TRIM stays 5, BIAS_EN[1] = 0 and CAL_MODE[1] = 0 throughout.
- ABORT during the second WAIT, with pre-cal TRIM = {8,8} -> next cycle state = IDLE, TRIM = {8,8}, BIAS_EN = 0, BUSY = 0, DONE = 0.
- START and TRIM_LOAD pulsed while BUSY -> both ignored, and the final codes equal those from the first scenario.
- From RUN, START with ABORT in the same cycle -> IDLE, trims kept at {9,3}, BIAS_EN = 0.
- Assert RST_N low mid-TRIAL -> TRIM = {8,8} and all control outputs 0 without waiting for a clock edge.
